// File: rtl/scarv_mem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32-style native memory port between the
// PicoRV32 core and the XCrypto COP; COP accesses outside a window get a bus error.
module scarv_mem_arbiter #(
  parameter logic [31:0] COP_WIN_BASE = 32'h0000_0000,
  parameter logic [31:0] COP_WIN_MASK = 32'h0000_0000
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        prv_mem_valid,
  input  logic        prv_mem_instr,
  input  logic [31:0] prv_mem_addr,
  input  logic [31:0] prv_mem_wdata,
  input  logic [3:0]  prv_mem_wstrb,
  output logic        prv_mem_ready,
  output logic [31:0] prv_mem_rdata,

  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_PRV = 2'd1,
    BUSY_COP = 2'd2,
    ERR_COP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        rr_last_q;  // 0: PRV won the last grant, 1: COP
  logic        mem_valid_q;
  logic        mem_instr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic        cop_in_win;
  logic        grant_prv;
  logic        grant_cop;

  assign cop_in_win = (cop_mem_addr & COP_WIN_MASK) == (COP_WIN_BASE & COP_WIN_MASK);

  // On a tie, the requester that did not win last time goes first.
  assign grant_prv = prv_mem_valid & (~cop_mem_cen | rr_last_q);
  assign grant_cop = cop_mem_cen & (~prv_mem_valid | ~rr_last_q);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples values from before the clock edge.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_prv) begin
            state_q     <= BUSY_PRV;
            rr_last_q   <= 1'b0;
            mem_valid_q <= 1'b1;
            mem_instr_q <= prv_mem_instr;
            mem_addr_q  <= prv_mem_addr;
            mem_wdata_q <= prv_mem_wdata;
            mem_wstrb_q <= prv_mem_wstrb;
          end else if (grant_cop) begin
            rr_last_q <= 1'b1;
            if (cop_in_win) begin
              state_q     <= BUSY_COP;
              mem_valid_q <= 1'b1;
              mem_instr_q <= 1'b0;
              mem_addr_q  <= cop_mem_addr;
              mem_wdata_q <= cop_mem_wdata;
              mem_wstrb_q <= cop_mem_wen ? cop_mem_ben : 4'b0000;
            end else begin
              // Out-of-window: answer with an error, never touch the shared port.
              state_q <= ERR_COP;
            end
          end
        end
        BUSY_PRV, BUSY_COP: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ERR_COP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  assign prv_mem_ready = (state_q == BUSY_PRV) & mem_ready;
  assign prv_mem_rdata = mem_rdata;

  assign cop_mem_rdata = mem_rdata;
  assign cop_mem_error = (state_q == ERR_COP);
  assign cop_mem_stall = cop_mem_cen &
                         ~(((state_q == BUSY_COP) & mem_ready) | (state_q == ERR_COP));

endmodule

// File: doc/scarv_mem_arbiter.md
Name: scarv_mem_arbiter

Overview:
Two-requester memory arbiter that shares one PicoRV32-style native memory port between the PicoRV32 core and the XCrypto COP SRAM-style memory port. The shared port feeds a single scarv_axi_adapter, so the integrated core+COP needs one AXI4-lite master instead of two. It uses round-robin arbitration, registers the winner's request, and rejects COP accesses outside a configurable address window with a bus error.

Parameters:
COP_WIN_BASE, 32'h0000_0000, base address of the COP-permitted window.
COP_WIN_MASK, 32'h0000_0000, address bits compared against COP_WIN_BASE. The access is in-window when (addr & MASK) == (BASE & MASK). The default of 0 permits all addresses.

Ports:
g_clk  input  1  global clock, rising edge
g_reset  input  1  asynchronous, active-high reset
prv_mem_valid  input  1  PicoRV32 request; held with stable payload until prv_mem_ready
prv_mem_instr  input  1  PicoRV32 fetch flag
prv_mem_addr  input  32  PicoRV32 address
prv_mem_wdata  input  32  PicoRV32 write data
prv_mem_wstrb  input  4  PicoRV32 byte strobes; 0 means read
prv_mem_ready  output  1  PicoRV32 transfer complete (one-cycle pulse)
prv_mem_rdata  output  32  PicoRV32 read data, valid with prv_mem_ready
cop_mem_cen  input  1  COP request; held with stable payload while cop_mem_stall is high
cop_mem_wen  input  1  COP write enable
cop_mem_addr  input  32  COP address (word aligned)
cop_mem_wdata  input  32  COP write data
cop_mem_ben  input  4  COP byte enables
cop_mem_rdata  output  32  COP read data, valid in the completing cycle
cop_mem_stall  output  1  COP stall
cop_mem_error  output  1  COP bus error, valid in the completing cycle
mem_valid  output  1  shared-port request
mem_instr  output  1  shared-port fetch flag
mem_addr  output  32  shared-port address
mem_wdata  output  32  shared-port write data
mem_wstrb  output  4  shared-port strobes
mem_ready  input  1  shared-port completion
mem_rdata  input  32  shared-port read data

Behaviour:
- States: IDLE, BUSY_PRV, BUSY_COP, ERR_COP. Registers: state, rr_last (0=PRV, 1=COP), mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb.
- Reset: state=IDLE, rr_last=1 (PRV wins the first tie), mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- Reset is asynchronous, so an in-flight transaction is abandoned. The downstream adapter shares the same reset.
- IDLE, single requester: that requester wins.
- IDLE, both requesting: the requester not equal to rr_last wins. rr_last is updated to the winner on grant.
- PRV wins: next state BUSY_PRV. Register mem_valid=1, mem_instr=prv_mem_instr, addr/wdata/wstrb from PRV.
- COP wins, in-window: next state BUSY_COP. Register mem_valid=1, mem_instr=0, mem_addr=cop_mem_addr, mem_wdata=cop_mem_wdata, mem_wstrb=cop_mem_wen ? cop_mem_ben : 4'b0000.
- COP wins, out-of-window: next state ERR_COP. mem_valid stays 0 and no downstream access is made.
- BUSY_x: the payload registers hold. When mem_ready=1, clear mem_valid and return to IDLE.
  - No back-to-back grant; there is at least one IDLE cycle between transactions.
  - mem_ready is ignored outside BUSY states.
- ERR_COP lasts exactly one cycle, then IDLE.
- Completion to PRV (combinational): prv_mem_ready = (state==BUSY_PRV) & mem_ready. prv_mem_rdata = mem_rdata.
- Completion to COP (combinational): cop_mem_rdata = mem_rdata. cop_mem_error = (state==ERR_COP). cop_mem_stall = cop_mem_cen & ~((state==BUSY_COP & mem_ready) | state==ERR_COP).
- Latency: request seen in IDLE at cycle N gives mem_valid at N+1. With zero-wait downstream, the requester completes at N+1.
- A losing requester waits: it wins the next IDLE cycle by round-robin, so worst-case wait is one foreign transaction.
- A requester dropping its request while not granted is ignored. Dropping while granted is a protocol violation: the arbiter completes the downstream transaction regardless and returns to IDLE.
- cop_mem_stall is 0 when cop_mem_cen=0. Outputs to the non-granted requester: ready=0, error=0, stall=cen.

Test Plan:
- Reset, then PRV read 0xC000_0000 with mem_ready at cycle 2 of the grant -> mem_valid high two cycles, mem_addr=0xC000_0000, mem_instr follows prv_mem_instr, prv_mem_ready pulses once with rdata 0x1234_5678.
- COP write addr 0x100, ben=4'b0110, wdata 0xAABBCCDD, zero-wait -> mem_wstrb=4'b0110, mem_instr=0, cop_mem_stall high in IDLE cycle, low on completion.
- PRV and COP requesting in the same cycle after reset -> PRV served first, then COP after one IDLE cycle. Repeating the simultaneous request after that -> PRV served first again (rr_last=COP), confirming alternation.
- COP_WIN_BASE=0x2000_0000, COP_WIN_MASK=0xF000_0000, COP read 0x3000_0000 -> mem_valid never asserts, cop_mem_error=1 and stall=0 for exactly one cycle. A later COP read 0x2000_0010 goes downstream.
- g_reset asserted while in BUSY_COP with mem_valid=1 -> mem_valid, mem_wstrb and mem_addr drop to 0 asynchronously before the next clock edge, state=IDLE. After release, PRV wins the first tie.
- Downstream holds mem_ready=0 for 20 cycles -> payload registers stable, stall stays high, no second grant. Competing PRV request is served right after completion plus one IDLE cycle.
